// File: rtl/ram_port_ctrl.sv
// Command front-end for a single-port RAM with a 2-cycle read latency. It provides
// read-credit flow control and a first-word-fall-through read-response FIFO.
module ram_port_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int MASK_WIDTH = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [MASK_WIDTH-1:0]   cmd_mask,
    input  logic [8*MASK_WIDTH-1:0] cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*MASK_WIDTH-1:0] rsp_data,
    output logic                    ram_en,
    output logic                    ram_wr,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [MASK_WIDTH-1:0]   ram_mask,
    output logic [8*MASK_WIDTH-1:0] ram_wrData,
    input  logic [8*MASK_WIDTH-1:0] ram_rdData
);

    localparam int DW = 8 * MASK_WIDTH;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int UW = $clog2(RSP_DEPTH + 3);

    logic          rd_s1;
    logic          rd_s2;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] fifo_mem [RSP_DEPTH];

    logic          fire;
    logic          rd_fire;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [UW-1:0] used;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Stage-1 valid doubles as the write-bubble flag: the RAM output register
    // loads during the cycle after a read, so a write in that cycle would corrupt it.
    // Credits count reads in flight plus reads already waiting in the FIFO.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        used      = UW'(rd_s1) + UW'(rd_s2) + UW'(count);
        credit_ok = (used < UW'(RSP_DEPTH));
        cmd_ready = 1'b0;
        if (resetn) begin
            cmd_ready = cmd_write ? !rd_s1 : credit_ok;
        end
    end

    assign fire       = cmd_valid && cmd_ready;
    assign rd_fire    = fire && !cmd_write;
    assign ram_en     = fire;
    assign ram_wr     = fire && cmd_write;
    assign ram_addr   = cmd_addr;
    assign ram_mask   = fire ? cmd_mask : '0;
    assign ram_wrData = cmd_data;

    assign push      = rd_s2;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_s1  <= 1'b0;
            rd_s2  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rd_s1 <= rd_fire;
            rd_s2 <= rd_s1;
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // NOTE: the payload array is deliberately not reset; count qualifies every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_rdData;
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Self-checking bench for ram_port_ctrl: a behavioural 2-cycle RAM, directed scenarios
// and a randomized run, all compared against a transaction-level scoreboard.
module tb_ram_port_ctrl;

    localparam int AW        = 10;
    localparam int MW        = 4;
    localparam int DW        = 32;
    localparam int RSP_DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [MW-1:0] cmd_mask;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ram_en;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_mask;
    logic [DW-1:0] ram_wrData;
    logic [DW-1:0] ram_rdData;

    always #5 clk = ~clk;

    ram_port_ctrl #(
        .ADDR_WIDTH(AW),
        .MASK_WIDTH(MW),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_mask  (cmd_mask),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_mask  (ram_mask),
        .ram_wrData(ram_wrData),
        .ram_rdData(ram_rdData)
    );

    // Single-port RAM: array read into an internal register, then an output
    // register that only loads while no write is being performed.
    logic [DW-1:0] ram_mem [2**AW];
    logic [DW-1:0] ram_q1;

    always @(posedge clk) begin
        if (ram_en && !ram_wr) ram_q1 <= ram_mem[ram_addr];
        if (!ram_wr) ram_rdData <= ram_q1;
        if (ram_en && ram_wr) begin
            for (int b = 0; b < MW; b++) begin
                if (ram_mask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wrData[8*b +: 8];
            end
        end
    end

    // Scoreboard: every fired read not yet popped, tagged with its issue cycle.
    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [2**AW];
    logic          prev_rd_fire;
    int unsigned   cyc;
    int            checks;
    int            errors;
    logic          last_obs_en;
    int            obs_fires;
    int            obs_pops;
    int            obs_valids;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, advance the model, return after the rising edge.
    task automatic step();
        logic exp_ready;
        logic exp_fire;
        logic exp_valid;
        @(negedge clk);
        if (!resetn) begin
            exp_q.delete();
            prev_rd_fire = 1'b0;
        end
        exp_ready = resetn && (cmd_write ? !prev_rd_fire : (exp_q.size() < RSP_DEPTH));
        exp_fire  = cmd_valid && exp_ready;
        exp_valid = (exp_q.size() != 0) && (exp_q[0].cyc + 3 <= cyc);

        check("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
        check("ram_en",    64'(ram_en),    64'(exp_fire));
        check("ram_wr",    64'(ram_wr),    64'(exp_fire && cmd_write));
        check("ram_mask",  64'(ram_mask),  exp_fire ? 64'(cmd_mask) : 64'(0));
        check("ram_addr",  64'(ram_addr),  64'(cmd_addr));
        if (exp_fire && cmd_write) check("ram_wrData", 64'(ram_wrData), 64'(cmd_data));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (exp_valid) check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));

        last_obs_en = ram_en;
        if (ram_en) obs_fires++;
        if (rsp_valid) obs_valids++;
        if (rsp_valid && rsp_ready) obs_pops++;

        if (exp_valid && rsp_ready) void'(exp_q.pop_front());
        if (exp_fire) begin
            if (cmd_write) begin
                for (int b = 0; b < MW; b++) begin
                    if (cmd_mask[b]) shadow[cmd_addr][8*b +: 8] = cmd_data[8*b +: 8];
                end
            end else begin
                exp_q.push_back('{cyc, shadow[cmd_addr]});
            end
        end
        prev_rd_fire = exp_fire && !cmd_write;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold one command until the DUT accepts it; returns the cycle in which it fired.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [MW-1:0] m,
                        input logic [DW-1:0] d, output int unsigned fire_cyc);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_mask  = m;
        cmd_data  = d;
        fire_cyc  = 0;
        for (int n = 0; n < 40; n++) begin
            fire_cyc = cyc;
            step();
            if (last_obs_en) break;
        end
        check("send_accepted", 64'(last_obs_en), 64'(1));
        cmd_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned fc;
        int unsigned prev_fc;
        int unsigned rd_fc;
        int unsigned rel_cyc;
        int          base;

        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_mask = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        checks = 0; errors = 0; cyc = 0; prev_rd_fire = 1'b0;
        obs_fires = 0; obs_pops = 0; obs_valids = 0; last_obs_en = 1'b0;

        // Reset held with a write offered: nothing may be accepted.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_mask = 4'hF;
        idle(2);
        cmd_valid = 1'b0;
        resetn = 1'b1;
        rel_cyc = cyc;

        // Initialise addresses 0..15 with back-to-back writes; the first fires right after release.
        prev_fc = 0;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, AW'(i), 4'hF, $urandom, fc);
            if (i == 0) check("ready_after_reset", 64'(fc), 64'(rel_cyc));
            else        check("write_b2b", 64'(fc), 64'(prev_fc + 1));
            prev_fc = fc;
        end

        // Single read: response three cycles after the read fires.
        rsp_ready = 1'b1;
        send(1'b1, 10'd5, 4'hF, 32'hA5A5_1234, fc);
        send(1'b0, 10'd5, 4'hF, 32'h0, fc);
        idle(2);
        #1;
        check("single_read_valid", 64'(rsp_valid), 64'(1));
        check("single_read_data",  64'(rsp_data),  64'(32'hA5A5_1234));
        idle(2);

        // Byte-lane masking.
        send(1'b1, 10'd7, 4'hF, 32'hFFFF_FFFF, fc);
        send(1'b1, 10'd7, 4'h5, 32'h0000_0000, fc);
        send(1'b0, 10'd7, 4'hF, 32'h0, fc);
        idle(2);
        #1;
        check("byte_mask_data", 64'(rsp_data), 64'(32'hFF00_FF00));
        idle(2);

        // Backpressure: four reads fill the credits, the fifth is refused until responses drain.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 4'hF, 32'h0, fc);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd4;
        base = obs_fires;
        idle(6);
        check("credit_block_fires", 64'(obs_fires - base), 64'(0));
        base = obs_pops;
        rsp_ready = 1'b1;
        send(1'b0, 10'd4, 4'hF, 32'h0, fc);
        send(1'b0, 10'd5, 4'hF, 32'h0, fc);
        idle(6);
        check("backpressure_rsp_count", 64'(obs_pops - base), 64'(6));

        // Read then write: the write waits one bubble cycle and the read returns the old data.
        send(1'b1, 10'd1, 4'hF, 32'h1111_1111, fc);
        send(1'b0, 10'd1, 4'hF, 32'h0, rd_fc);
        send(1'b1, 10'd1, 4'hF, 32'h2222_2222, fc);
        check("write_bubble_gap", 64'(fc - rd_fc), 64'(2));
        #1;
        check("read_old_valid", 64'(rsp_valid), 64'(1));
        check("read_old_data",  64'(rsp_data),  64'(32'h1111_1111));
        idle(2);

        // Streaming reads at one per cycle.
        base = obs_pops;
        for (int i = 0; i < 16; i++) begin
            send(1'b0, AW'(i), 4'hF, 32'h0, fc);
            if (i > 0) check("read_b2b", 64'(fc), 64'(prev_fc + 1));
            prev_fc = fc;
        end
        idle(5);
        check("stream_rsp_count", 64'(obs_pops - base), 64'(16));

        // Reset while two reads are in flight: nothing may emerge afterwards.
        send(1'b0, 10'd2, 4'hF, 32'h0, fc);
        send(1'b0, 10'd3, 4'hF, 32'h0, fc);
        resetn = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0;
        #1;
        check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        step();
        cmd_valid = 1'b0;
        resetn = 1'b1;
        base = obs_valids;
        idle(8);
        check("no_rsp_after_reset", 64'(obs_valids - base), 64'(0));

        // Randomized traffic over a small address window.
        for (int n = 0; n < 600; n++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_write = ($urandom_range(0, 2) == 0);
            cmd_addr  = AW'($urandom_range(0, 15));
            cmd_mask  = MW'($urandom);
            cmd_data  = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(8);
        #1;
        check("drain_empty", 64'(rsp_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width.
REQ-002 SHALL have parameter MASK_WIDTH, default 4, byte lanes per word; data width DW = 8*MASK_WIDTH.
REQ-003 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries (>=2).
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake; a command fires when both are high.
REQ-007 SHALL have ports cmd_write in 1, cmd_addr in ADDR_WIDTH, cmd_mask in MASK_WIDTH, cmd_data in DW: command payload.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DW: read-response stream.
REQ-009 SHALL have ports ram_en out 1, ram_wr out 1, ram_addr out ADDR_WIDTH, ram_mask out MASK_WIDTH, ram_wrData out DW: single-port RAM drive.
REQ-010 SHALL have port ram_rdData in DW: RAM read data; 2-cycle read latency; output register loads only while ram_wr=0.

Function
REQ-011 ram_en SHALL equal the cmd fire; ram_wr/addr/mask/wrData SHALL be the combinational pass-through of cmd_write/addr/mask/data.
REQ-012 When ram_en=0, ram_wr SHALL be 0 and ram_mask SHALL be 0.
REQ-013 Read issued in cycle t SHALL have ram_rdData sampled at the end of cycle t+2 and pushed into the response FIFO.
REQ-014 A 2-stage valid shift register SHALL track in-flight reads; stage 2 valid triggers the FIFO push.
REQ-015 cmd_ready SHALL be 0 for a write in the cycle immediately after a read fire (write bubble; protects the RAM output register load).
REQ-016 Read-credit rule: cmd_ready SHALL be 0 for a read when (in-flight reads + FIFO occupancy) >= RSP_DEPTH.
REQ-017 cmd_ready SHALL NOT depend on rsp_ready combinationally; writes are not blocked by credit exhaustion.
REQ-018 Writes SHALL produce no response.
REQ-019 Response FIFO SHALL be first-word-fall-through: rsp_valid=1 whenever non-empty; rsp_data = head entry; pop on rsp_valid&&rsp_ready.
REQ-020 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order, including at full and at one entry.
REQ-021 FIFO pointers SHALL wrap modulo RSP_DEPTH; the FIFO SHALL never overflow (guaranteed by REQ-016) or underflow.
REQ-022 Responses SHALL be returned in read-issue order.
REQ-023 Back-to-back reads SHALL sustain 1 read/cycle while credits allow; back-to-back writes SHALL sustain 1 write/cycle.

Reset
REQ-024 During resetn=0: cmd_ready=0, rsp_valid=0, ram_en=0, ram_wr=0, ram_mask=0, FIFO empty, in-flight stages cleared, bubble flag cleared.
REQ-025 Reset asserted mid-operation SHALL discard in-flight reads and FIFO contents; no response SHALL emerge after release for reads issued before reset.
REQ-026 cmd_ready SHALL first be able to assert in the first cycle after resetn deasserts.

Verification
REQ-027 Single read: write addr 5 = 0xA5A5_1234 mask 0xF, then read addr 5 -> rsp_valid 3 cycles after read fire, rsp_data=0xA5A5_1234.
REQ-028 Byte mask: write addr 7 = 0xFFFF_FFFF, then write 0x0000_0000 mask 0x5, read -> 0xFF00_FF00.
REQ-029 Backpressure: rsp_ready=0, offer 6 reads -> exactly 4 fire, cmd_ready stays 0; raise rsp_ready -> 4 responses in order, remaining 2 then fire.
REQ-030 Read-then-write: read addr 1 fires in cycle t, write pending -> cmd_ready=0 in t+1, write fires in t+2, read returns old data.
REQ-031 Streaming: 16 consecutive reads with rsp_ready=1 -> one read per cycle, 16 in-order responses, no stalls.
REQ-032 Reset mid-flight: 2 reads issued, resetn pulsed low next cycle -> all outputs at reset values, no response ever appears.
